car_drive_unit: RTL

- Per-car plant/actuator responder on the far side of the elevator command interface. It consumes one car's up/down/stop commands from the main controller and produces that car's floor location and door status.
- It models motor travel between floors and the door open/hold/close sequence with cycle counters.
- It serves as synthesizable car-side logic and as the closed-loop stimulus for controller verification.
- Two instances are used, one per car; their locations concatenate into the controller's 6-bit location bus and their door bits into its 2-bit door bus.

---
 rtl/car_drive_unit.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/car_drive_unit.sv
// Car-side plant model: floor travel and door open/hold/close sequencing for one elevator car.
// state        | meaning
// IDLE         | door closed, stationary, accepting commands
// MOVE_UP      | travelling one floor up, commands ignored
// MOVE_DOWN    | travelling one floor down, commands ignored
// ARRIVE       | one-cycle stop at the new floor, accepting commands
// DOOR_OPENING | door opening
// DOOR_OPEN    | door held open, obstruction restarts the hold
// DOOR_CLOSING | door closing, obstruction returns to DOOR_OPEN
module car_drive_unit #(
    parameter int NUM_FLOORS          = 8,
    parameter int FLOOR_TRAVEL_CYCLES = 16,
    parameter int DOOR_MOVE_CYCLES    = 8,
    parameter int DOOR_HOLD_CYCLES    = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          up,
    input  logic                          down,
    input  logic                          stop,
    input  logic                          door_obstruct,
    output logic [$clog2(NUM_FLOORS)-1:0] location,
    output logic                          door_status,
    output logic                          moving,
    output logic                          cmd_error
);
    localparam int LW    = $clog2(NUM_FLOORS);
    localparam int MAX_A = (FLOOR_TRAVEL_CYCLES > DOOR_MOVE_CYCLES) ? FLOOR_TRAVEL_CYCLES : DOOR_MOVE_CYCLES;
    localparam int MAX_C = (MAX_A > DOOR_HOLD_CYCLES) ? MAX_A : DOOR_HOLD_CYCLES;
    localparam int CW    = (MAX_C > 1) ? $clog2(MAX_C) : 1;

    localparam logic [LW-1:0] TOP_FLOOR   = LW'(NUM_FLOORS - 1);
    localparam logic [CW-1:0] TRAVEL_LOAD = CW'(FLOOR_TRAVEL_CYCLES - 1);
    localparam logic [CW-1:0] MOVE_LOAD   = CW'(DOOR_MOVE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LOAD   = CW'(DOOR_HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        MOVE_UP,
        MOVE_DOWN,
        ARRIVE,
        DOOR_OPENING,
        DOOR_OPEN,
        DOOR_CLOSING
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [LW-1:0]   location_nxt;
    logic            door_status_nxt;
    logic            moving_nxt;
    logic            cmd_error_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            location    <= '0;
            door_status <= 1'b1;
            moving      <= 1'b0;
            cmd_error   <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            location    <= location_nxt;
            door_status <= door_status_nxt;
            moving      <= moving_nxt;
            cmd_error   <= cmd_error_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        location_nxt  = location;
        cmd_error_nxt = 1'b0;

        unique case (state)
            // ARRIVE decodes commands exactly like IDLE; with nothing legal it settles in IDLE.
            IDLE, ARRIVE: begin
                state_nxt = IDLE;
                if (stop) begin
                    state_nxt = DOOR_OPENING;
                    cnt_nxt   = MOVE_LOAD;
                end else if (up && down) begin
                    cmd_error_nxt = 1'b1;
                end else if (up) begin
                    if (location != TOP_FLOOR) begin
                        state_nxt = MOVE_UP;
                        cnt_nxt   = TRAVEL_LOAD;
                    end else begin
                        cmd_error_nxt = 1'b1;
                    end
                end else if (down) begin
                    if (location != '0) begin
                        state_nxt = MOVE_DOWN;
                        cnt_nxt   = TRAVEL_LOAD;
                    end else begin
                        cmd_error_nxt = 1'b1;
                    end
                end
            end
            MOVE_UP, MOVE_DOWN: begin
                if (cnt == '0) begin
                    state_nxt    = ARRIVE;
                    location_nxt = (state == MOVE_UP) ? location + LW'(1) : location - LW'(1);
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            DOOR_OPENING: begin
                if (cnt == '0) begin
                    state_nxt = DOOR_OPEN;
                    cnt_nxt   = HOLD_LOAD;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            DOOR_OPEN: begin
                if (door_obstruct) begin
                    cnt_nxt = HOLD_LOAD;
                end else if (cnt == '0) begin
                    state_nxt = DOOR_CLOSING;
                    cnt_nxt   = MOVE_LOAD;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            DOOR_CLOSING: begin
                if (door_obstruct) begin
                    state_nxt = DOOR_OPEN;
                    cnt_nxt   = HOLD_LOAD;
                end else if (cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        moving_nxt      = (state_nxt == MOVE_UP) || (state_nxt == MOVE_DOWN);
        door_status_nxt = !((state_nxt == DOOR_OPENING) || (state_nxt == DOOR_OPEN) ||
                            (state_nxt == DOOR_CLOSING));
    end
endmodule
